// File: rtl/ram_read_arbiter.sv
// Dual-port RAM read arbiter: round-robin grants of up to two requesters
// per cycle, with read data queued in a response FIFO with tag and address.
module ram_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]  i_req_tag,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [ADDR_W-1:0]         o_ram_addr0,
  output logic [ADDR_W-1:0]         o_ram_addr1,
  input  logic [DATA_W-1:0]         i_ram_data0,
  input  logic [DATA_W-1:0]         i_ram_data1,
  output logic                      o_resp_valid,
  input  logic                      i_resp_ready,
  output logic [DATA_W-1:0]         o_resp_data,
  output logic [TAG_W-1:0]          o_resp_tag,
  output logic [ADDR_W-1:0]         o_resp_addr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + TAG_W + ADDR_W;

  logic [IW-1:0] r_rr;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [EW-1:0] r_mem [RESP_DEPTH];

  logic          w_pop;
  logic [CW-1:0] w_free;
  logic          w_found0;
  logic          w_found1;
  logic [IW-1:0] w_idx0;
  logic [IW-1:0] w_idx1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [IW-1:0] w_nxt0;
  logic [IW-1:0] w_nxt1;
  logic [PW-1:0] w_wr1;
  logic [EW-1:0] w_ent0;
  logic [EW-1:0] w_ent1;
  logic [EW-1:0] w_head;

  assign o_resp_valid = !rst && (r_count != '0);
  assign w_pop        = o_resp_valid && i_resp_ready;

  // A slot freed by this cycle's pop may be refilled in the same cycle
  assign w_free = CW'(RESP_DEPTH) - r_count + CW'(w_pop);

  always_comb begin : scan
    int          t;
    logic [IW-1:0] v_idx;
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_idx0   = '0;
    w_idx1   = '0;
    t        = 0;
    v_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      t = int'(r_rr) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      v_idx = IW'(t);
      if (i_req_valid[v_idx]) begin
        if (!w_found0) begin
          w_found0 = 1'b1;
          w_idx0   = v_idx;
        end else if (!w_found1) begin
          w_found1 = 1'b1;
          w_idx1   = v_idx;
        end
      end
    end
  end

  assign w_gnt0 = !rst && w_found0 && (w_free >= CW'(1));
  assign w_gnt1 = !rst && w_found1 && (w_free >= CW'(2));

  always_comb begin
    o_req_ready = '0;
    if (w_gnt0) o_req_ready[w_idx0] = 1'b1;
    if (w_gnt1) o_req_ready[w_idx1] = 1'b1;
  end

  assign o_ram_addr0 = w_gnt0 ?
    i_req_addr[w_idx0*ADDR_W +: ADDR_W] : '0;
  assign o_ram_addr1 = w_gnt1 ?
    i_req_addr[w_idx1*ADDR_W +: ADDR_W] : '0;

  assign w_ent0 = {i_ram_data0,
                   i_req_tag[w_idx0*TAG_W +: TAG_W],
                   o_ram_addr0};
  assign w_ent1 = {i_ram_data1,
                   i_req_tag[w_idx1*TAG_W +: TAG_W],
                   o_ram_addr1};

  assign w_nxt0 = (int'(w_idx0) == NUM_REQ - 1) ?
    '0 : w_idx0 + IW'(1);
  assign w_nxt1 = (int'(w_idx1) == NUM_REQ - 1) ?
    '0 : w_idx1 + IW'(1);
  assign w_wr1  = r_wr + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_wr    <= r_wr + PW'(w_gnt0) + PW'(w_gnt1);
      r_count <= r_count + CW'(w_gnt0)
               + CW'(w_gnt1) - CW'(w_pop);
      if (w_gnt1)      r_rr <= w_nxt1;
      else if (w_gnt0) r_rr <= w_nxt0;
    end
  end

  // Storage needs no reset; grants are already suppressed during rst
  always_ff @(posedge clk) begin
    if (w_gnt0) r_mem[r_wr]  <= w_ent0;
    if (w_gnt1) r_mem[w_wr1] <= w_ent1;
  end

  assign w_head = r_mem[r_rd];

  assign {o_resp_data, o_resp_tag, o_resp_addr} =
    o_resp_valid ? w_head : '0;

endmodule

// File: doc/ram_read_arbiter.md
RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the RAM read ports.
REQ-002 Parameter ADDR_W, default 16, RAM word address width.
REQ-003 Parameter DATA_W, default 16, RAM word width.
REQ-004 Parameter TAG_W, default 8, requester tag width (instruction number).
REQ-005 Parameter RESP_DEPTH, default 4, response FIFO depth; power of two, at least 2.
REQ-006 Reset rst, synchronous, active-high; clock clk.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 req_valid  input  NUM_REQ  per-requester read request.
REQ-010 req_addr  input  NUM_REQ*ADDR_W  per-requester word address; requester i occupies slice i.
REQ-011 req_tag  input  NUM_REQ*TAG_W  per-requester tag, returned with the data.
REQ-012 req_ready  output  NUM_REQ  grant; request i is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-013 ram_addr0 / ram_addr1  output  ADDR_W each  drive RAM read ports 0 and 1.
REQ-014 ram_data0 / ram_data1  input  DATA_W each  RAM read data, combinational from ram_addr0 / ram_addr1 in the same cycle.
REQ-015 resp_valid  output  1  response FIFO head is valid.
REQ-016 resp_ready  input  1  consumer accepts the head.
REQ-017 resp_data  output  DATA_W  head data.
REQ-018 resp_tag  output  TAG_W  head tag.
REQ-019 resp_addr  output  ADDR_W  head address (debug).

Function
REQ-020 Each cycle, grant at most 2 requests: G = min(2, free, number of valid requests).
REQ-021 free = RESP_DEPTH - count, plus 1 if resp_valid && resp_ready this cycle.
REQ-022 Requester selection is round-robin starting at index rr_ptr, wrapping modulo NUM_REQ.
  - First valid requester found is assigned to port 0.
  - Second valid requester found is assigned to port 1.
REQ-023 req_ready is combinational and high only for granted requesters; it never depends on req_ready itself.
REQ-024 ram_addr0 / ram_addr1 carry the granted addresses in the grant cycle; an unused port drives 0.
REQ-025 In the grant cycle, push {data, tag, addr} into the FIFO: port 0 entry first, then port 1 entry.
REQ-026 Latency: a request accepted at edge N has its data visible at resp_* at edge N+1 at the earliest (FIFO empty case).
REQ-027 After any grant, rr_ptr becomes (last granted index + 1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-028 FIFO ordering is strict FIFO; resp_* hold stable while resp_valid && !resp_ready.
REQ-029 Push and pop in the same cycle are both allowed: count_next = count + G - pop.
REQ-030 Full FIFO with no pop: G = 0, all req_ready low, ram_addr0 = ram_addr1 = 0.
REQ-031 Empty FIFO: resp_valid low; resp_data, resp_tag and resp_addr are 0.
REQ-032 Read and write pointers are log2(RESP_DEPTH) bits and wrap naturally; count is log2(RESP_DEPTH)+1 bits.
REQ-033 free = 1 with two valid requesters: only the port 0 (round-robin first) requester is granted.

Reset
REQ-034 While rst is high, at each edge: rr_ptr=0, FIFO pointers=0, count=0.
REQ-035 During reset cycles, all req_ready are forced low, resp_valid is low, and ram_addr0/1 are 0.
REQ-036 Reset asserted mid-operation discards all FIFO contents; no response is produced for requests granted in the reset cycle.

Verification
REQ-037 RAM model: word 52=16'h1210, 54=16'h0e10. Stimulus: req 0 (addr 52, tag 0) and req 1 (addr 54, tag 1) valid one cycle after reset, resp_ready=1. Required: both granted in the same cycle; responses {1210,tag0} then {0e10,tag1} on consecutive cycles, the first one cycle after the grant.
REQ-038 All 4 requesters held valid, resp_ready=1. Required: grant pairs (0,1), (2,3), (0,1), ...; rr_ptr sequence 0, 2, 0.
REQ-039 resp_ready=0, all requesters valid. Required: 2 grants, then 2 grants, then req_ready stays 0 with count=4; raise resp_ready for 1 cycle -> exactly 1 grant that cycle (free=1).
REQ-040 Only requester 3 valid, rr_ptr=1. Required: requester 3 granted on port 0; ram_addr1=0; rr_ptr becomes 0.
REQ-041 FIFO holds 3 entries, rst pulsed for 1 cycle mid-stream. Required: resp_valid=0 the next cycle; count=0; rr_ptr=0; no stale response appears afterward.
REQ-042 Random valid/ready traffic over 10k cycles. Required: every accepted request is returned exactly once with the correct data/tag pair; per-port order is preserved; no requester is starved for more than NUM_REQ/2 granting cycles.
